// File: rtl/rv32_decode_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_decode_queue : fetch-to-decode instruction FIFO, flush + bypass       |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module rv32_decode_queue #(
   parameter int DEPTH   = 4,
   parameter int XLEN    = 32,
   parameter int CAUSE_W = 4,
   parameter int BYPASS  = 0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush_in,
   input  logic                       in_valid_in,
   output logic                       in_ready_out,
   input  logic [XLEN-1:0]            pc_in,
   input  logic [XLEN-1:0]            instr_in,
   input  logic                       exception_in,
   input  logic [CAUSE_W-1:0]         exception_cause_in,
   input  logic                       branch_predicted_taken_in,
   output logic                       out_valid_out,
   input  logic                       out_ready_in,
   output logic [XLEN-1:0]            pc_out,
   output logic [XLEN-1:0]            instr_out,
   output logic                       exception_out,
   output logic [CAUSE_W-1:0]         exception_cause_out,
   output logic                       branch_predicted_taken_out,
   output logic [$clog2(DEPTH+1)-1:0] count_out
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH+1);
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

   logic [XLEN-1:0]    r_pc_mem    [DEPTH];
   logic [XLEN-1:0]    r_instr_mem [DEPTH];
   logic               r_exc_mem   [DEPTH];
   logic [CAUSE_W-1:0] r_cause_mem [DEPTH];
   logic               r_bp_mem    [DEPTH];

   logic [c_ptr_w-1:0] r_rd;
   logic [c_ptr_w-1:0] r_wr;
   logic [c_cnt_w-1:0] r_count;

   logic w_empty, w_fwd, w_ready, w_valid, w_push, w_pop, w_write, w_read;

   always_comb begin
      w_empty = (r_count == '0);
      w_fwd   = (BYPASS != 0) && w_empty;
      w_ready = (r_count != c_full) && !flush_in;
      w_push  = in_valid_in && w_ready;
      // Forward path is only live while empty, out of reset and not flushing.
      if (w_fwd) begin
         w_valid = in_valid_in && !flush_in && reset_n;
      end else begin
         w_valid = !w_empty;
      end
      w_pop   = w_valid && out_ready_in;
      w_write = w_push && !(w_fwd && w_pop);
      w_read  = w_pop && !w_fwd;
   end

   always_comb begin
      pc_out                     = '0;
      instr_out                  = '0;
      exception_out              = 1'b0;
      exception_cause_out        = '0;
      branch_predicted_taken_out = 1'b0;
      if (w_valid) begin
         if (w_fwd) begin
            pc_out                     = pc_in;
            instr_out                  = instr_in;
            exception_out              = exception_in;
            exception_cause_out        = exception_cause_in;
            branch_predicted_taken_out = branch_predicted_taken_in;
         end else begin
            pc_out                     = r_pc_mem[r_rd];
            instr_out                  = r_instr_mem[r_rd];
            exception_out              = r_exc_mem[r_rd];
            exception_cause_out        = r_cause_mem[r_rd];
            branch_predicted_taken_out = r_bp_mem[r_rd];
         end
      end
   end

   assign in_ready_out  = w_ready;
   assign out_valid_out = w_valid;
   assign count_out     = r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (flush_in) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_write) r_wr <= r_wr + c_ptr_w'(1);
         if (w_read)  r_rd <= r_rd + c_ptr_w'(1);
         r_count <= r_count + c_cnt_w'(w_write) - c_cnt_w'(w_read);
      end
   end

   // Slot storage is intentionally not reset; valid tracking masks stale data.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_pc_mem[r_wr]    <= pc_in;
         r_instr_mem[r_wr] <= instr_in;
         r_exc_mem[r_wr]   <= exception_in;
         r_cause_mem[r_wr] <= exception_cause_in;
         r_bp_mem[r_wr]    <= branch_predicted_taken_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32_decode_queue : storage and bypass instances vs. queue model        |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_rv32_decode_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
      logic [3:0]  cause;
      logic        bp;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n, flush, in_valid, out_ready, exc_in, bp_in;
   logic [31:0] pc_in, instr_in;
   logic [3:0]  cause_in;

   logic a_ready, a_valid, a_exc, a_bp, b_ready, b_valid, b_exc, b_bp;
   logic [31:0] a_pc, a_instr, b_pc, b_instr;
   logic [3:0]  a_cause, b_cause;
   logic [2:0]  a_count, b_count;

   int n_vec = 0;
   int n_err = 0;

   ent_t qa[$];
   ent_t qb[$];
   logic ea_valid, ea_ready, eb_valid, eb_ready;
   ent_t ea_head, eb_head;
   logic [2:0] ea_count, eb_count;

   always #5 clk = ~clk;

   rv32_decode_queue #(.DEPTH(DEPTH), .XLEN(32), .CAUSE_W(4), .BYPASS(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .flush_in(flush),
      .in_valid_in(in_valid), .in_ready_out(a_ready),
      .pc_in(pc_in), .instr_in(instr_in), .exception_in(exc_in),
      .exception_cause_in(cause_in), .branch_predicted_taken_in(bp_in),
      .out_valid_out(a_valid), .out_ready_in(out_ready),
      .pc_out(a_pc), .instr_out(a_instr), .exception_out(a_exc),
      .exception_cause_out(a_cause), .branch_predicted_taken_out(a_bp),
      .count_out(a_count));

   rv32_decode_queue #(.DEPTH(DEPTH), .XLEN(32), .CAUSE_W(4), .BYPASS(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .flush_in(flush),
      .in_valid_in(in_valid), .in_ready_out(b_ready),
      .pc_in(pc_in), .instr_in(instr_in), .exception_in(exc_in),
      .exception_cause_in(cause_in), .branch_predicted_taken_in(bp_in),
      .out_valid_out(b_valid), .out_ready_in(out_ready),
      .pc_out(b_pc), .instr_out(b_instr), .exception_out(b_exc),
      .exception_cause_out(b_cause), .branch_predicted_taken_out(b_bp),
      .count_out(b_count));

   function automatic ent_t cur_in();
      return {pc_in, instr_in, exc_in, cause_in, bp_in};
   endfunction

   // Expected outputs from the current queue contents and current inputs.
   function automatic void model_exp();
      ea_ready = (qa.size() != DEPTH) && !flush;
      ea_valid = (qa.size() != 0);
      ea_head  = ea_valid ? qa[0] : '0;
      ea_count = 3'(qa.size());
      eb_ready = (qb.size() != DEPTH) && !flush;
      if (qb.size() == 0) begin
         eb_valid = in_valid && !flush && reset_n;
         eb_head  = eb_valid ? cur_in() : '0;
      end else begin
         eb_valid = 1'b1;
         eb_head  = qb[0];
      end
      eb_count = 3'(qb.size());
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic e, input logic [3:0] c, input logic bp,
                        input logic ordy, input logic fl);
      in_valid = v; pc_in = pc; instr_in = ins; exc_in = e; cause_in = c;
      bp_in = bp; out_ready = ordy; flush = fl;
   endtask

   // Advance one clock, updating the reference queues with the sampled handshakes.
   task automatic tick();
      ent_t c;
      model_exp();
      c = cur_in();
      @(posedge clk);
      if (!reset_n) begin
         qa.delete(); qb.delete();
      end else if (flush) begin
         qa.delete(); qb.delete();
      end else begin
         if (ea_valid && out_ready) void'(qa.pop_front());
         if (in_valid && ea_ready) qa.push_back(c);
         if (qb.size() == 0) begin
            if (eb_valid && !out_ready) qb.push_back(c);
         end else begin
            if (out_ready) void'(qb.pop_front());
            if (in_valid && eb_ready) qb.push_back(c);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      n_vec++;
      if ({a_valid, a_count, a_ready, a_pc, a_instr} !== {1'b0, 3'd0, 1'b1, 64'h0}) begin
         n_err++;
         $display("FAIL reset_a: got valid=%0b count=%0d ready=%0b pc=%h instr=%h, want 0/0/1/0/0",
                  a_valid, a_count, a_ready, a_pc, a_instr);
      end
      n_vec++;
      if ({b_valid, b_count, b_ready, b_pc, b_instr} !== {1'b0, 3'd0, 1'b1, 64'h0}) begin
         n_err++;
         $display("FAIL reset_b: got valid=%0b count=%0d ready=%0b pc=%h instr=%h, want 0/0/1/0/0",
                  b_valid, b_count, b_ready, b_pc, b_instr);
      end
      tick(); tick();
      reset_n = 1'b1;
      qa.delete(); qb.delete();
      tick();
   endtask

   task automatic test_fill();
      logic [31:0] exp_pc;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 4'h0, i[0], 1'b0, 1'b0);
         if (i == 4) begin
            #1;
            n_vec++;
            if ({a_count, a_ready} !== {3'd4, 1'b0}) begin
               n_err++;
               $display("FAIL fill_full: got count=%0d ready=%0b, want 4/0", a_count, a_ready);
            end
         end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
         #1;
         exp_pc = 32'(i * 4);
         n_vec++;
         if ({a_valid, a_pc} !== {1'b1, exp_pc}) begin
            n_err++;
            $display("FAIL fill_order[%0d]: got valid=%0b pc=%h, want 1 pc=%h", i, a_valid, a_pc, exp_pc);
         end
         tick();
      end
      #1;
      n_vec++;
      if ({a_valid, a_count} !== {1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL fill_drained: got valid=%0b count=%0d, want 0/0", a_valid, a_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc;
      drive(1'b1, 32'h100, 32'h13, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 32'h100 + 32'(i * 4), 32'h13, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
         #1;
         exp_pc = 32'h100 + 32'((i - 1) * 4);
         n_vec++;
         if ({a_count, a_valid, a_pc} !== {3'd1, 1'b1, exp_pc}) begin
            n_err++;
            $display("FAIL stream[%0d]: got count=%0d valid=%0b pc=%h, want 1/1 pc=%h",
                     i, a_count, a_valid, a_pc, exp_pc);
         end
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      tick(); tick();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h200 + 32'(i * 4), 32'h33, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'hDEAD0000, 32'h33, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      #1;
      n_vec++;
      if ({a_count, a_ready} !== {3'd3, 1'b0}) begin
         n_err++;
         $display("FAIL flush_pre: got count=%0d ready=%0b, want 3/0", a_count, a_ready);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      #1;
      n_vec++;
      if ({a_count, a_valid, b_count, b_valid} !== {3'd0, 1'b0, 3'd0, 1'b0}) begin
         n_err++;
         $display("FAIL flush_post: got a=%0d/%0b b=%0d/%0b, want 0/0 0/0",
                  a_count, a_valid, b_count, b_valid);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h300 + 32'(i * 4), 32'h33, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
         #1;
         n_vec++;
         if (a_pc === 32'hDEAD0000 || b_pc === 32'hDEAD0000) begin
            n_err++;
            $display("FAIL flush_ghost: got a_pc=%h b_pc=%h, want not DEAD0000", a_pc, b_pc);
         end
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_bypass();
      drive(1'b1, 32'h500, 32'h00000013, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      #1;
      n_vec++;
      if ({b_valid, b_instr, b_pc, a_valid} !== {1'b1, 32'h13, 32'h500, 1'b0}) begin
         n_err++;
         $display("FAIL bypass_fwd: got b_valid=%0b instr=%h pc=%h a_valid=%0b, want 1 13 500 0",
                  b_valid, b_instr, b_pc, a_valid);
      end
      tick();
      drive(1'b1, 32'h504, 32'h00000013, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      n_vec++;
      if ({b_count, b_valid} !== {3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL bypass_consumed: got count=%0d valid=%0b, want 0/1", b_count, b_valid);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      #1;
      n_vec++;
      if ({b_count, b_valid, b_pc} !== {3'd1, 1'b1, 32'h504}) begin
         n_err++;
         $display("FAIL bypass_held: got count=%0d valid=%0b pc=%h, want 1/1/504", b_count, b_valid, b_pc);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      tick(); tick();
   endtask

   task automatic test_exception();
      drive(1'b1, 32'h400, 32'hFFFFFFFF, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h404, 32'h13, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      #1;
      n_vec++;
      if ({a_valid, a_exc, a_cause, a_pc} !== {1'b1, 1'b1, 4'd1, 32'h400}) begin
         n_err++;
         $display("FAIL exc_head: got valid=%0b exc=%0b cause=%0d pc=%h, want 1/1/1/400",
                  a_valid, a_exc, a_cause, a_pc);
      end
      tick();
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({a_valid, a_count, a_pc, a_exc, b_valid, b_count, b_pc} !== {1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0}) begin
         n_err++;
         $display("FAIL async_reset: got a=%0b/%0d/%h/%0b b=%0b/%0d/%h, want all 0",
                  a_valid, a_count, a_pc, a_exc, b_valid, b_count, b_pc);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 7) == 0,
               4'($urandom), 1'($urandom), (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
               $urandom_range(0, 24) == 0);
         model_exp();
         #1;
         n_vec++;
         if ({a_valid, a_ready, a_count, a_pc, a_instr, a_exc, a_cause, a_bp} !==
             {ea_valid, ea_ready, ea_count, ea_head}) begin
            n_err++;
            $display("FAIL rand_a[%0d]: got v=%0b r=%0b c=%0d pc=%h in=%h e=%0b ca=%0d bp=%0b, want v=%0b r=%0b c=%0d head=%h",
                     i, a_valid, a_ready, a_count, a_pc, a_instr, a_exc, a_cause, a_bp,
                     ea_valid, ea_ready, ea_count, ea_head);
         end
         n_vec++;
         if ({b_valid, b_ready, b_count, b_pc, b_instr, b_exc, b_cause, b_bp} !==
             {eb_valid, eb_ready, eb_count, eb_head}) begin
            n_err++;
            $display("FAIL rand_b[%0d]: got v=%0b r=%0b c=%0d pc=%h in=%h e=%0b ca=%0d bp=%0b, want v=%0b r=%0b c=%0d head=%h",
                     i, b_valid, b_ready, b_count, b_pc, b_instr, b_exc, b_cause, b_bp,
                     eb_valid, eb_ready, eb_count, eb_head);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_back_to_back();
      test_flush();
      test_bypass();
      test_exception();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
